// File: rtl/row_fifo.sv
// row_fifo: first-word-fall-through FIFO of row entries between splicer pipeline stages.
// Each entry is one ROW_SIZE x WIDTH row. Status flags and count decode from the
// registered pointers only. Overflow and underflow are sticky until clear or reset.
//
// Ports:
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset
//   clear         synchronous flush; overrides we/re and clears the sticky flags
//   data_in       row to write
//   we, re        write strobe and pop strobe
//   data_out      head row (FWFT), all zeros when empty
//   full, empty   occupancy extremes
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
//   count         occupied entries, 0..DEPTH
//   overflow      sticky: a write was dropped because the FIFO was full
//   underflow     sticky: a read arrived while the FIFO was empty
module row_fifo #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned ROW_SIZE      = 3,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned AFULL_THRESH  = DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               clear,
  input  logic [ROW_SIZE-1:0][WIDTH-1:0]     data_in,
  input  logic                               we,
  input  logic                               re,
  output logic [ROW_SIZE-1:0][WIDTH-1:0]     data_out,
  output logic                               full,
  output logic                               empty,
  output logic                               almost_full,
  output logic                               almost_empty,
  output logic [$clog2(DEPTH):0]             count,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [PW-1:0] AfullThr  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AemptyThr = PW'(AEMPTY_THRESH);

  // Storage carries no reset; validity is tracked purely by the pointers.
  logic [ROW_SIZE-1:0][WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] put_ptr_q, put_ptr_d;
  logic [PW-1:0] get_ptr_q, get_ptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_en;

  // Status decode from registered pointers only.
  assign count        = put_ptr_q - get_ptr_q;
  assign empty        = (put_ptr_q == get_ptr_q);
  assign full         = (put_ptr_q[AW] != get_ptr_q[AW]) &&
                        (put_ptr_q[AW-1:0] == get_ptr_q[AW-1:0]);
  assign almost_full  = (count >= AfullThr);
  assign almost_empty = (count <= AemptyThr);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    put_ptr_d   = put_ptr_q;
    get_ptr_d   = get_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    if (clear) begin
      put_ptr_d   = '0;
      get_ptr_d   = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (we) begin
        // A full FIFO still accepts a write when a pop happens in the same cycle.
        if (!full || re) begin
          wr_en     = 1'b1;
          put_ptr_d = put_ptr_q + PW'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end
      if (re) begin
        if (!empty) begin
          get_ptr_d = get_ptr_q + PW'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      put_ptr_q   <= '0;
      get_ptr_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      put_ptr_q   <= put_ptr_d;
      get_ptr_q   <= get_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[put_ptr_q[AW-1:0]] <= data_in;
    end
  end

  // FWFT head; forced to zero when empty so stale storage never leaks out.
  always_comb begin
    data_out = '0;
    if (!empty) begin
      data_out = mem_q[get_ptr_q[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_row_fifo.sv
// Self-checking bench for row_fifo. A scoreboard queue models the FIFO contents;
// popped rows are compared against the DUT head sampled before the popping edge.
// A second instance with AFULL_THRESH = 2 and AEMPTY_THRESH = 0 shares the stimulus.
module tb_row_fifo;

  localparam int unsigned W     = 32;
  localparam int unsigned ROW   = 3;
  localparam int unsigned DEPTH = 4;

  typedef logic [ROW-1:0][W-1:0] row_t;

  logic       clock;
  logic       reset_n;
  logic       clear;
  row_t       data_in;
  logic       we;
  logic       re;
  row_t       data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  row_t       data_out2;
  logic       full2, empty2, almost_full2, almost_empty2;
  logic [2:0] count2;
  logic       overflow2, underflow2;

  int total = 0;
  int bad   = 0;

  row_t sb[$];
  row_t dout_snap;
  row_t exp_row;
  bit   pop_v, push_v;

  row_fifo #(
    .WIDTH(W), .ROW_SIZE(ROW), .DEPTH(DEPTH), .AFULL_THRESH(DEPTH - 1), .AEMPTY_THRESH(1)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .data_in(data_in), .we(we), .re(re),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  row_fifo #(
    .WIDTH(W), .ROW_SIZE(ROW), .DEPTH(DEPTH), .AFULL_THRESH(2), .AEMPTY_THRESH(0)
  ) u_dut2 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .data_in(data_in), .we(we), .re(re),
    .data_out(data_out2), .full(full2), .empty(empty2), .almost_full(almost_full2),
    .almost_empty(almost_empty2), .count(count2), .overflow(overflow2),
    .underflow(underflow2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic row_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c);
    row_t r;
    r[2] = a;
    r[1] = b;
    r[0] = c;
    return r;
  endfunction

  // Head as seen during the cycle, i.e. before the edge that may pop it.
  always @(negedge clock) dout_snap = data_out;

  always @(negedge reset_n) sb.delete();

  // Scoreboard: applies each accepted write/pop in the same priority as the FIFO.
  always @(posedge clock) begin
    if (reset_n) begin
      if (clear) begin
        sb.delete();
      end else begin
        pop_v  = re && (sb.size() > 0);
        push_v = we && ((sb.size() < DEPTH) || pop_v);
        if (pop_v) begin
          exp_row = sb.pop_front();
          total++;
          if (dout_snap !== exp_row) begin
            bad++;
            $display("FAIL pop_data got=%h want=%h", dout_snap, exp_row);
          end
        end
        if (push_v) sb.push_back(data_in);
      end
    end
  end

  task automatic cycle(input logic c, input logic w, input logic r, input row_t row);
    clear   = c;
    we      = w;
    re      = r;
    data_in = row;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 0; we = 0; re = 0; data_in = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    total++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
        almost_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
        data_out !== row_t'(0)) begin
      bad++;
      $display("FAIL reset_state got cnt=%0d e=%b f=%b af=%b ae=%b ov=%b un=%b do=%h",
               count, empty, full, almost_full, almost_empty, overflow, underflow, data_out);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_fill();
    row_t rows[4];
    rows[0] = mk(1, 2, 3);
    rows[1] = mk(4, 5, 6);
    rows[2] = mk(7, 8, 9);
    rows[3] = mk(10, 11, 12);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, rows[i]);
      total++;
      if (count !== 3'(i + 1) || almost_full !== (i + 1 >= 3) || full !== (i + 1 == 4) ||
          data_out !== rows[0]) begin
        bad++;
        $display("FAIL fill_%0d got cnt=%0d af=%b f=%b do=%h", i, count, almost_full, full,
                 data_out);
      end
      total++;
      if (almost_full2 !== (i + 1 >= 2) || almost_empty2 !== 1'b0) begin
        bad++;
        $display("FAIL fill_thr2_%0d got af=%b ae=%b want af=%b ae=0", i, almost_full2,
                 almost_empty2, (i + 1 >= 2));
      end
    end
  endtask

  task automatic test_overflow();
    row_t rows[4];
    rows[0] = mk(1, 2, 3);
    rows[1] = mk(4, 5, 6);
    rows[2] = mk(7, 8, 9);
    rows[3] = mk(10, 11, 12);
    cycle(0, 1, 0, mk(13, 14, 15));
    total++;
    if (count !== 3'd4 || overflow !== 1'b1 || full !== 1'b1) begin
      bad++;
      $display("FAIL overflow got cnt=%0d ov=%b f=%b want 4 1 1", count, overflow, full);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (data_out !== rows[i]) begin
        bad++;
        $display("FAIL drain_%0d got=%h want=%h", i, data_out, rows[i]);
      end
      cycle(0, 0, 1, '0);
    end
    total++;
    if (empty !== 1'b1 || count !== 3'd0 || data_out !== row_t'(0)) begin
      bad++;
      $display("FAIL drained got e=%b cnt=%0d do=%h", empty, count, data_out);
    end
  endtask

  task automatic test_simul_rw();
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, mk(32'h10 + i, 32'h20 + i, 32'h30 + i));
    cycle(0, 1, 1, mk(32'hAA, 32'hBB, 32'hCC));
    total++;
    if (count !== 3'd4 || full !== 1'b1 || data_out !== mk(32'h11, 32'h21, 32'h31)) begin
      bad++;
      $display("FAIL rw_full got cnt=%0d f=%b do=%h", count, full, data_out);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, '0);
    total++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL rw_drain got e=%b un=%b want 1 0", empty, underflow);
    end
    cycle(0, 1, 1, mk(32'h55, 32'h66, 32'h77));
    total++;
    if (count !== 3'd1 || underflow !== 1'b1 || data_out !== mk(32'h55, 32'h66, 32'h77)) begin
      bad++;
      $display("FAIL rw_empty got cnt=%0d un=%b do=%h", count, underflow, data_out);
    end
    cycle(0, 0, 1, '0);
    cycle(0, 0, 1, '0);
    total++;
    if (underflow !== 1'b1 || empty !== 1'b1 || count !== 3'd0) begin
      bad++;
      $display("FAIL underflow_sticky got un=%b e=%b cnt=%0d", underflow, empty, count);
    end
  endtask

  task automatic test_wrap();
    int errs = 0;
    cycle(0, 1, 0, mk(32'h100, 32'h200, 32'h300));
    for (int i = 1; i < 10; i++) begin
      cycle(0, 1, 0, mk(32'h100 + i, 32'h200 + i, 32'h300 + i));
      if (count !== 3'd2 || full !== 1'b0 || count !== 3'(sb.size())) errs++;
      cycle(0, 0, 1, '0);
      if (count !== 3'd1 || full !== 1'b0 || data_out !== mk(32'h100 + i, 32'h200 + i,
                                                             32'h300 + i)) errs++;
    end
    cycle(0, 0, 1, '0);
    total++;
    if (errs != 0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL wrap got errs=%0d e=%b want errs=0 e=1", errs, empty);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, mk(i, i, i));
    cycle(0, 1, 0, mk(32'hF0, 32'hF1, 32'hF2));
    cycle(0, 0, 1, '0);
    total++;
    if (count !== 3'd3 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL clear_setup got cnt=%0d ov=%b want 3 1", count, overflow);
    end
    cycle(1, 1, 1, mk(32'hDE, 32'hAD, 32'hBE));
    total++;
    if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
        data_out !== row_t'(0)) begin
      bad++;
      $display("FAIL clear got cnt=%0d e=%b ov=%b un=%b do=%h", count, empty, overflow,
               underflow, data_out);
    end
    cycle(0, 0, 0, '0);
  endtask

  task automatic test_async_reset();
    cycle(0, 1, 0, mk(32'hA1, 32'hA2, 32'hA3));
    total++;
    if (almost_full2 !== 1'b0 || almost_empty2 !== 1'b0 || almost_empty !== 1'b1) begin
      bad++;
      $display("FAIL thr_cnt1 got af2=%b ae2=%b ae=%b want 0 0 1", almost_full2,
               almost_empty2, almost_empty);
    end
    cycle(0, 1, 0, mk(32'hB1, 32'hB2, 32'hB3));
    total++;
    if (count !== 3'd2 || almost_full2 !== 1'b1 || almost_empty2 !== 1'b0 ||
        almost_empty !== 1'b0) begin
      bad++;
      $display("FAIL thr_cnt2 got cnt=%0d af2=%b ae2=%b ae=%b", count, almost_full2,
               almost_empty2, almost_empty);
    end
    we = 0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (count !== 3'd0 || empty !== 1'b1 || data_out !== row_t'(0) || count2 !== 3'd0 ||
        almost_full2 !== 1'b0 || almost_empty2 !== 1'b1) begin
      bad++;
      $display("FAIL async_reset got cnt=%0d e=%b do=%h cnt2=%0d af2=%b ae2=%b", count,
               empty, data_out, count2, almost_full2, almost_empty2);
    end
    reset_n = 1'b1;
    #1;
    total++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      bad++;
      $display("FAIL post_reset got e=%b cnt=%0d", empty, count);
    end
    cycle(0, 1, 0, mk(32'hC1, 32'hC2, 32'hC3));
    total++;
    if (count !== 3'd1 || data_out !== mk(32'hC1, 32'hC2, 32'hC3)) begin
      bad++;
      $display("FAIL reuse got cnt=%0d do=%h", count, data_out);
    end
    cycle(0, 0, 1, '0);
    cycle(0, 0, 0, '0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_simul_rw();
    test_wrap();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
